// File: rtl/memoria_datos_dumper_if.sv
// memoria_datos_dumper_if: memory-side bus and word-stream handshake used by
// the memoria_datos dumper. The master modport is the dumper; the slave
// modport is the memory plus the word consumer.
interface memoria_datos_dumper_if #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 11
);
  // memory port
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_ena;
  logic                  o_regcea;
  logic                  o_wea;
  logic                  o_soft_reset;
  logic                  i_reset_ack;
  logic [RAM_WIDTH-1:0]  i_data;
  // dumped word stream
  logic [RAM_WIDTH-1:0]  o_word;
  logic                  o_word_valid;
  logic                  i_word_ready;

  modport master (
    output o_addr, o_ena, o_regcea, o_wea, o_soft_reset, o_word, o_word_valid,
    input  i_reset_ack, i_data, i_word_ready
  );

  modport slave (
    input  o_addr, o_ena, o_regcea, o_wea, o_soft_reset, o_word, o_word_valid,
    output i_reset_ack, i_data, i_word_ready
  );
endinterface

// File: rtl/memoria_datos_dumper.sv
// memoria_datos_dumper: read-only sweep of memoria_datos for the debug unit.
// A start pulse optionally soft-clears the memory, then every address
// 0..RAM_DEPTH-1 is read and offered on a valid/ready word stream.
// Optional feature macro: MEMDUMP_CHECKSUM_EN appends an XOR checksum word
// (CHK state) after the last data word.
// All outputs are registered; reset is synchronous and active-high.
module memoria_datos_dumper #(
  parameter int RAM_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_clear,
  memoria_datos_dumper_if.master bus,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]      LP_CNT_LOAD  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0]      LP_CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
`ifdef MEMDUMP_CHECKSUM_EN
    S_DONE  = 3'd5,
    S_CHK   = 3'd6
`else
    S_DONE  = 3'd5
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [RAM_WIDTH-1:0]  r_word;
  logic [RAM_WIDTH-1:0]  w_word_next;
  logic                  r_valid;
  logic                  w_valid_next;
  logic                  r_ena;
  logic                  w_ena_next;
  logic                  r_soft_reset;
  logic                  w_soft_reset_next;
  logic                  r_busy;
  logic                  w_busy_next;
  logic                  r_done;
  logic                  w_done_next;

`ifdef MEMDUMP_CHECKSUM_EN
  logic [RAM_WIDTH-1:0]  r_acc;
  logic [RAM_WIDTH-1:0]  w_acc_next;

  // One step of the running XOR checksum over accepted words.
  function automatic logic [RAM_WIDTH-1:0] f_xor_step(
    input logic [RAM_WIDTH-1:0] acc,
    input logic [RAM_WIDTH-1:0] word
  );
    return acc ^ word;
  endfunction
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus next values of every registered output.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_cnt_next   = r_cnt;
    w_word_next  = r_word;
    w_valid_next = r_valid;
`ifdef MEMDUMP_CHECKSUM_EN
    w_acc_next   = r_acc;
`endif

    case (r_state)
      S_IDLE, S_DONE: begin
        // start is only honoured here; while busy it is ignored
        if (i_start) begin
          w_addr_next = '0;
`ifdef MEMDUMP_CHECKSUM_EN
          w_acc_next  = '0;
`endif
          if (i_clear) begin
            w_state_next = S_CLEAR;
          end else begin
            w_state_next = S_ISSUE;
          end
        end else begin
          w_state_next = r_state;
        end
      end

      S_CLEAR: begin
        // soft reset held low until the memory acknowledges; no timeout
        if (bus.i_reset_ack) begin
          w_addr_next  = '0;
          w_state_next = S_ISSUE;
        end else begin
          w_state_next = S_CLEAR;
        end
      end

      S_ISSUE: begin
        w_cnt_next   = LP_CNT_LOAD;
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        if (r_cnt == '0) begin
          w_word_next  = bus.i_data;
          w_valid_next = 1'b1;
          w_state_next = S_HOLD;
        end else begin
          w_cnt_next = r_cnt - LP_CNT_ONE;
        end
      end

      S_HOLD: begin
        if (bus.i_word_ready) begin
          w_valid_next = 1'b0;
`ifdef MEMDUMP_CHECKSUM_EN
          w_acc_next   = f_xor_step(r_acc, r_word);
`endif
          if (r_addr == LP_LAST_ADDR) begin
`ifdef MEMDUMP_CHECKSUM_EN
            // checksum word follows immediately, with the same hold rules
            w_word_next  = f_xor_step(r_acc, r_word);
            w_valid_next = 1'b1;
            w_state_next = S_CHK;
`else
            w_state_next = S_DONE;
`endif
          end else begin
            w_addr_next  = r_addr + LP_ADDR_ONE;
            w_state_next = S_ISSUE;
          end
        end else begin
          w_state_next = S_HOLD;
        end
      end

`ifdef MEMDUMP_CHECKSUM_EN
      S_CHK: begin
        if (bus.i_word_ready) begin
          w_valid_next = 1'b0;
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CHK;
        end
      end
`endif

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Control outputs follow the state being entered, so they are registered
    // yet line up exactly with that state.
    w_ena_next        = (w_state_next == S_ISSUE);
    w_soft_reset_next = (w_state_next != S_CLEAR);
    w_busy_next       = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
    w_done_next       = (w_state_next == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr       <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_ena        <= 1'b0;
      r_soft_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef MEMDUMP_CHECKSUM_EN
      r_acc        <= '0;
`endif
    end else begin
      r_addr       <= w_addr_next;
      r_cnt        <= w_cnt_next;
      r_word       <= w_word_next;
      r_valid      <= w_valid_next;
      r_ena        <= w_ena_next;
      r_soft_reset <= w_soft_reset_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
`ifdef MEMDUMP_CHECKSUM_EN
      r_acc        <= w_acc_next;
`endif
    end
  end

  assign bus.o_addr       = r_addr;
  assign bus.o_ena        = r_ena;
  assign bus.o_regcea     = r_ena;
  assign bus.o_wea        = 1'b0;
  assign bus.o_soft_reset = r_soft_reset;
  assign bus.o_word       = r_word;
  assign bus.o_word_valid = r_valid;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule

// File: tb/tb_memoria_datos_dumper.sv
// tb_memoria_datos_dumper: scoreboard bench. Instance A uses READ_LATENCY=1,
// instance B uses READ_LATENCY=2; both dump a 4-word memory model.
module tb_memoria_datos_dumper;
  localparam int W     = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 4;
  // reset vector of {addr, ena, regcea, wea, soft_reset, valid, busy, done}
  localparam logic [31:0] RST_VEC  = {14'd0, 11'd0, 7'b0001000};
  localparam logic [31:0] HOLD_A1  = {14'd0, 11'd1, 7'b0001110};

  typedef struct {
    logic [31:0] d;
    int          gap;
  } exp_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, clear_a, ready_a, busy_a, done_a;
  logic rst_b, start_b, clear_b, ready_b, busy_b, done_b;
  logic preset;
  logic ack_a = 1'b0;
  logic [31:0] q_a = 32'd0;
  logic [31:0] q1_b = 32'd0;
  logic [31:0] q_b = 32'd0;
  logic [31:0] mem_a [0:3];
  logic [31:0] mem_b [0:3];
  int clr_cnt_a = 0;
  int cyc = 0;
  int last_a = 0;
  int last_b = 0;
  logic wea_seen = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  memoria_datos_dumper_if #(.RAM_WIDTH(W), .ADDR_WIDTH(AW)) bus_a ();
  memoria_datos_dumper_if #(.RAM_WIDTH(W), .ADDR_WIDTH(AW)) bus_b ();

  memoria_datos_dumper #(.RAM_WIDTH(W), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .READ_LATENCY(1)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_start(start_a), .i_clear(clear_a),
    .bus(bus_a), .o_busy(busy_a), .o_done(done_a)
  );

  memoria_datos_dumper #(.RAM_WIDTH(W), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .READ_LATENCY(2)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_start(start_b), .i_clear(clear_b),
    .bus(bus_b), .o_busy(busy_b), .o_done(done_b)
  );

  assign bus_a.i_data       = q_a;
  assign bus_a.i_reset_ack  = ack_a;
  assign bus_a.i_word_ready = ready_a;
  assign bus_b.i_data       = q_b;
  assign bus_b.i_reset_ack  = 1'b0;
  assign bus_b.i_word_ready = ready_b;

  // Memory model A: one-cycle read, soft clear acknowledged after 3 low cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preset) begin
      mem_a[0] <= 32'hDB; mem_a[1] <= 32'h05; mem_a[2] <= 32'h02; mem_a[3] <= 32'h00;
    end else if (bus_a.o_soft_reset === 1'b0 && clr_cnt_a == 2) begin
      for (int i = 0; i < 4; i++) mem_a[i] <= 32'd0;
    end
    if (bus_a.o_soft_reset === 1'b0) begin
      if (clr_cnt_a == 2) ack_a <= 1'b1;
      clr_cnt_a <= clr_cnt_a + 1;
    end else begin
      clr_cnt_a <= 0;
      ack_a     <= 1'b0;
    end
    if (bus_a.o_ena === 1'b1) q_a <= mem_a[bus_a.o_addr[1:0]];
  end

  // Memory model B: two-cycle read pipeline.
  always @(posedge clk) begin
    if (preset) begin
      mem_b[0] <= 32'hDB; mem_b[1] <= 32'h05; mem_b[2] <= 32'h02; mem_b[3] <= 32'h00;
    end
    if (bus_b.o_ena === 1'b1) q1_b <= mem_b[bus_b.o_addr[1:0]];
    q_b <= q1_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_a();
    return {14'd0, bus_a.o_addr, bus_a.o_ena, bus_a.o_regcea, bus_a.o_wea,
            bus_a.o_soft_reset, bus_a.o_word_valid, busy_a, done_a};
  endfunction

  // Monitor: pops the scoreboard on every accepted word and checks spacing.
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.o_wea === 1'b1 || bus_b.o_wea === 1'b1) wea_seen = 1'b1;
    if (bus_a.o_word_valid === 1'b1 && ready_a === 1'b1) begin
      if (sb_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_word_a: got %h, required no word", bus_a.o_word);
      end else begin
        e = sb_a.pop_front();
        chk("word_a", bus_a.o_word, e.d);
        if (e.gap != 0) chk("gap_a", 32'(cyc - last_a), 32'(e.gap));
      end
      last_a = cyc;
    end
    if (bus_b.o_word_valid === 1'b1 && ready_b === 1'b1) begin
      if (sb_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_word_b: got %h, required no word", bus_b.o_word);
      end else begin
        e = sb_b.pop_front();
        chk("word_b", bus_b.o_word, e.d);
        if (e.gap != 0) chk("gap_b", 32'(cyc - last_b), 32'(e.gap));
      end
      last_b = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] w0, w1, w2, w3, csum, input int g1, g2, g3);
    sb_a.push_back('{d: w0, gap: 0});
    sb_a.push_back('{d: w1, gap: g1});
    sb_a.push_back('{d: w2, gap: g2});
    sb_a.push_back('{d: w3, gap: g3});
`ifdef MEMDUMP_CHECKSUM_EN
    sb_a.push_back('{d: csum, gap: 0});
`else
    if (csum === 32'hFFFF_FFFF) sb_a.push_back('{d: csum, gap: 0});
`endif
  endtask

  task automatic wait_done_a(input string name);
    int n = 0;
    while (done_a !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk(name, 32'(done_a), 32'd1);
  endtask

  task automatic start_dump_a(input logic clr);
    start_a = 1'b1; clear_a = clr;
    tick(1);
    start_a = 1'b0; clear_a = 1'b0;
  endtask

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; clear_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; clear_b = 1'b0; ready_b = 1'b1; preset = 1'b0;
    tick(3);
    chk("reset_ctrl_a", pack_a(), RST_VEC);
    chk("reset_word_a", bus_a.o_word, 32'd0);
    chk("reset_soft_b", 32'(bus_b.o_soft_reset), 32'd1);
    rst_a = 1'b0; rst_b = 1'b0;
    preset = 1'b1; tick(1); preset = 1'b0;

    // plain dump, ready held high; a start+clear mid-dump must be ignored
    push_a(32'hDB, 32'h05, 32'h02, 32'h00, 32'hDC, 3, 3, 3);
    start_dump_a(1'b0);
    chk("busy_after_start", 32'(busy_a), 32'd1);
    tick(4);
    start_dump_a(1'b1);
    chk("start_ignored_soft", 32'(bus_a.o_soft_reset), 32'd1);
    wait_done_a("done_plain");
    chk("sb_a_empty_plain", 32'(sb_a.size()), 32'd0);

    // clear then dump: all zeros
    push_a(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3, 3, 3);
    start_dump_a(1'b1);
    chk("clear_soft_low", 32'(bus_a.o_soft_reset), 32'd0);
    chk("done_cleared_on_start", 32'(done_a), 32'd0);
    n = 0;
    while (ack_a !== 1'b1 && n < 50) begin tick(1); n++; end
    chk("ack_seen", 32'(ack_a), 32'd1);
    chk("soft_low_at_ack", 32'(bus_a.o_soft_reset), 32'd0);
    tick(1);
    chk("soft_high_after_ack", 32'(bus_a.o_soft_reset), 32'd1);
    chk("issue_after_ack", 32'(bus_a.o_ena), 32'd1);
    wait_done_a("done_clear");

    // stall 10 cycles in HOLD at address 1
    preset = 1'b1; tick(1); preset = 1'b0;
    push_a(32'hDB, 32'h05, 32'h02, 32'h00, 32'hDC, 0, 3, 3);
    start_dump_a(1'b0);
    n = 0;
    while (!(bus_a.o_ena === 1'b1 && bus_a.o_addr == 11'd1) && n < 50) begin tick(1); n++; end
    chk("issue_addr1_seen", 32'(bus_a.o_addr), 32'd1);
    ready_a = 1'b0;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      chk("hold_ctrl", pack_a(), HOLD_A1);
      chk("hold_word", bus_a.o_word, 32'h05);
      tick(1);
    end
    ready_a = 1'b1;
    wait_done_a("done_stall");

    // reset mid-CLEAR
    start_dump_a(1'b1);
    chk("in_clear", 32'(bus_a.o_soft_reset), 32'd0);
    rst_a = 1'b1; tick(1);
    chk("reset_mid_clear", pack_a(), RST_VEC);
    rst_a = 1'b0;

    // reset mid-HOLD
    preset = 1'b1; tick(1); preset = 1'b0;
    ready_a = 1'b0;
    start_dump_a(1'b0);
    n = 0;
    while (bus_a.o_word_valid !== 1'b1 && n < 50) begin tick(1); n++; end
    chk("hold_word0", bus_a.o_word, 32'hDB);
    rst_a = 1'b1; tick(1);
    chk("reset_mid_hold", pack_a(), RST_VEC);
    chk("reset_mid_hold_word", bus_a.o_word, 32'd0);
    rst_a = 1'b0; ready_a = 1'b1;
    tick(1);
    push_a(32'hDB, 32'h05, 32'h02, 32'h00, 32'hDC, 3, 3, 3);
    start_dump_a(1'b0);
    wait_done_a("done_after_reset");

    // READ_LATENCY=2 instance: 4 cycles per word
    sb_b.push_back('{d: 32'hDB, gap: 0});
    sb_b.push_back('{d: 32'h05, gap: 4});
    sb_b.push_back('{d: 32'h02, gap: 4});
    sb_b.push_back('{d: 32'h00, gap: 4});
`ifdef MEMDUMP_CHECKSUM_EN
    sb_b.push_back('{d: 32'hDC, gap: 0});
`endif
    start_b = 1'b1; tick(1); start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 200) begin tick(1); n++; end
    chk("done_b", 32'(done_b), 32'd1);

    tick(2);
    chk("wea_never_high", 32'(wea_seen), 32'd0);
    chk("sb_a_empty", 32'(sb_a.size()), 32'd0);
    chk("sb_b_empty", 32'(sb_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
